// File: rtl/pw_gated_mem.sv
// pw_gated_mem: access-controlled register-file memory that sits behind the
// password checker. It serves a valid/ready request port with a one-cycle
// response and an error flag. Access is granted by unlock_pulse. The block
// relocks on lock_req or after TIMEOUT idle cycles. Addresses at or above
// RO_BASE are write-protected. With CLEAR_ON_LOCK set, every lock event
// scrubs the whole array to zero before access can be granted again.
module pw_gated_mem #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 4,
  parameter int DEPTH         = 16,
  parameter int RO_BASE       = 12,
  parameter int TIMEOUT       = 1000,
  parameter int CLEAR_ON_LOCK = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              unlock_pulse,
  input  logic              lock_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              locked,
  output logic              clearing
);

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_OPEN   = 2'd1,
    ST_CLEAR  = 2'd2
  } state_t;

  // The idle counter only has to reach TIMEOUT-1. It keeps one bit when the
  // timeout is disabled or trivially short.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  // Range checks use one extra bit so that DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   RO_X      = (ADDR_W + 1)'(RO_BASE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state;
  state_t              state_next;
  logic [CNT_W-1:0]    idle_cnt;
  logic [ADDR_W-1:0]   scrub_addr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                req_err;
  logic                idle_expire;
  logic                lock_event;
  logic [ADDR_W:0]     addr_x;

  // Request handshake. Requests stall only while the scrub sweep runs.
  assign req_ready = (state != ST_CLEAR);
  assign accept    = req_valid & req_ready;
  assign addr_x    = {1'b0, req_addr};

  // A request is judged against the state it meets at its accept edge.
  assign req_err = (state == ST_LOCKED)
                 | (addr_x >= DEPTH_X)
                 | (req_wr & (addr_x >= RO_X));

  // Expiry fires in the last idle cycle. A transaction or a fresh unlock in
  // that cycle restarts the window instead.
  assign idle_expire = (TIMEOUT > 0) && (state == ST_OPEN) &&
                       (idle_cnt == CNT_LAST) && !accept && !unlock_pulse;

  assign lock_event = (state == ST_OPEN) && (lock_req || idle_expire);

  assign locked   = (state != ST_OPEN);
  assign clearing = (state == ST_CLEAR);

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_LOCKED;
    else     state <= state_next;
  end

  // Next-state decode. lock_req beats unlock_pulse, and CLEAR ignores both.
  // NOTE: state_next is given its hold value first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_LOCKED: begin
        if (unlock_pulse && !lock_req) state_next = ST_OPEN;
      end
      ST_OPEN: begin
        if (lock_event) begin
          state_next = (CLEAR_ON_LOCK != 0) ? ST_CLEAR : ST_LOCKED;
        end
      end
      ST_CLEAR: begin
        if (scrub_addr == LAST_ADDR) state_next = ST_LOCKED;
      end
      default: state_next = ST_LOCKED;
    endcase
  end

  // Idle counter. It counts OPEN cycles without a transaction and sits at
  // zero outside OPEN, so entry into OPEN always starts from zero.
  always_ff @(posedge clk) begin
    if (rst || (TIMEOUT == 0) || (state != ST_OPEN) ||
        accept || unlock_pulse || lock_event) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  // Scrub address. It stays at zero outside CLEAR and walks up to the last
  // word, where it stops without wrapping.
  always_ff @(posedge clk) begin
    if (rst || (state != ST_CLEAR)) begin
      scrub_addr <= '0;
    end else if (scrub_addr != LAST_ADDR) begin
      scrub_addr <= scrub_addr + ADDR_W'(1);
    end
  end

  // Storage array. It is written either by the scrub sweep or by an accepted
  // write that passed the access checks.
  // NOTE: the array deliberately has no reset. Its contents survive rst, and
  // a scrub interrupted by rst stays partial.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem[scrub_addr] <= '0;
      end else if (accept && req_wr && !req_err) begin
        mem[req_addr] <= req_wdata;
      end
    end
  end

  // Response register. A response follows every accept by one cycle. A write
  // leaves the read data untouched, and with no response both fields hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_err <= req_err;
        if (req_err)      rsp_rdata <= '0;
        else if (!req_wr) rsp_rdata <= mem[req_addr];
      end
    end
  end

endmodule

// File: tb/tb_pw_gated_mem.sv
// tb_pw_gated_mem: drives three configurations of pw_gated_mem with directed
// vectors:
//   u0  defaults with TIMEOUT = 8          : access, protection, timeout, priority
//   u1  DEPTH = 10, RO_BASE = 8, no timeout, scrub on lock : range and boundaries
//   u2  RO_BASE = 16, TIMEOUT = 8, scrub on lock           : sweep and reset mid-sweep
// A cycle-level model derived from the behavioural rules is checked against
// every output on every falling edge. Literal expectations pin the model.
module tb_pw_gated_mem;

  logic       clk;
  logic       rst;
  logic       unl  [3];
  logic       lk   [3];
  logic       vld  [3];
  logic       wr   [3];
  logic [3:0] addr [3];
  logic [7:0] wd   [3];
  logic       rdy  [3];
  logic       rv   [3];
  logic [7:0] rd   [3];
  logic       rer  [3];
  logic       lkd  [3];
  logic       clr  [3];

  int p_depth [3] = '{16, 10, 16};
  int p_ro    [3] = '{12, 8, 16};
  int p_to    [3] = '{8, 0, 8};
  int p_clr   [3] = '{0, 1, 1};

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 0;

  pw_gated_mem #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RO_BASE(12),
                 .TIMEOUT(8), .CLEAR_ON_LOCK(0)) u0 (
    .clk(clk), .rst(rst), .unlock_pulse(unl[0]), .lock_req(lk[0]),
    .req_valid(vld[0]), .req_ready(rdy[0]), .req_wr(wr[0]),
    .req_addr(addr[0]), .req_wdata(wd[0]), .rsp_valid(rv[0]),
    .rsp_rdata(rd[0]), .rsp_err(rer[0]), .locked(lkd[0]), .clearing(clr[0]));

  pw_gated_mem #(.DATA_W(8), .ADDR_W(4), .DEPTH(10), .RO_BASE(8),
                 .TIMEOUT(0), .CLEAR_ON_LOCK(1)) u1 (
    .clk(clk), .rst(rst), .unlock_pulse(unl[1]), .lock_req(lk[1]),
    .req_valid(vld[1]), .req_ready(rdy[1]), .req_wr(wr[1]),
    .req_addr(addr[1]), .req_wdata(wd[1]), .rsp_valid(rv[1]),
    .rsp_rdata(rd[1]), .rsp_err(rer[1]), .locked(lkd[1]), .clearing(clr[1]));

  pw_gated_mem #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RO_BASE(16),
                 .TIMEOUT(8), .CLEAR_ON_LOCK(1)) u2 (
    .clk(clk), .rst(rst), .unlock_pulse(unl[2]), .lock_req(lk[2]),
    .req_valid(vld[2]), .req_ready(rdy[2]), .req_wr(wr[2]),
    .req_addr(addr[2]), .req_wdata(wd[2]), .rsp_valid(rv[2]),
    .rsp_rdata(rd[2]), .rsp_err(rer[2]), .locked(lkd[2]), .clearing(clr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Mode: 0 = locked, 1 = open, 2 = scrubbing.
  int         m_mode [3];
  int         m_idle [3];
  int         m_pos  [3];
  bit         m_rv   [3];
  bit         m_er   [3];
  logic [7:0] m_rd   [3];
  bit         m_rdk  [3];
  logic [7:0] mm     [3][16];
  bit         mk     [3][16];

  initial begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 16; j++) mk[i][j] = 1'b0;
    end
  end

  task automatic leave_open(input int i);
    if (p_clr[i] != 0) begin
      m_mode[i] = 2;
      m_pos[i]  = 0;
    end else begin
      m_mode[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int a;
    bit acc;
    bit bad;
    a = int'(addr[i]);
    if (rst) begin
      m_mode[i] = 0; m_idle[i] = 0; m_rv[i] = 0; m_er[i] = 0;
      m_rd[i] = 8'h00; m_rdk[i] = 1;
      return;
    end
    acc = vld[i] && (m_mode[i] != 2);
    m_rv[i] = acc;
    if (acc) begin
      bad = (m_mode[i] == 0) || (a >= p_depth[i]) || (wr[i] && a >= p_ro[i]);
      if (bad) begin
        m_er[i] = 1; m_rd[i] = 8'h00; m_rdk[i] = 1;
      end else if (wr[i]) begin
        m_er[i] = 0; mm[i][a] = wd[i]; mk[i][a] = 1;
      end else begin
        m_er[i] = 0; m_rd[i] = mm[i][a]; m_rdk[i] = mk[i][a];
      end
    end
    case (m_mode[i])
      0: if (unl[i] && !lk[i]) begin m_mode[i] = 1; m_idle[i] = 0; end
      1: begin
        if (lk[i]) leave_open(i);
        else if (unl[i] || acc) m_idle[i] = 0;
        else begin
          m_idle[i]++;
          if (p_to[i] > 0 && m_idle[i] == p_to[i]) leave_open(i);
        end
      end
      default: begin
        mm[i][m_pos[i]] = 8'h00;
        mk[i][m_pos[i]] = 1;
        m_pos[i]++;
        if (m_pos[i] == p_depth[i]) m_mode[i] = 0;
      end
    endcase
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every output of every instance is compared against the model each cycle.
  // Read data is skipped only while it comes from a never-written word.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("u%0d rsp_valid", i), rv[i], m_rv[i]);
        check($sformatf("u%0d rsp_err", i), rer[i], m_er[i]);
        if (m_rdk[i]) check($sformatf("u%0d rsp_rdata", i), rd[i], m_rd[i]);
        check($sformatf("u%0d req_ready", i), rdy[i], m_mode[i] != 2);
        check($sformatf("u%0d locked", i), lkd[i], m_mode[i] != 1);
        check($sformatf("u%0d clearing", i), clr[i], m_mode[i] == 2);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Present one cycle of inputs to instance i, then return to idle. On return
  // the outputs show the result of that cycle.
  task automatic drive(input int i, input bit u, input bit l, input bit v,
                       input bit w, input int a, input int d);
    unl[i] = u; lk[i] = l; vld[i] = v; wr[i] = w;
    addr[i] = 4'(a); wd[i] = 8'(d);
    @(negedge clk);
    unl[i] = 0; lk[i] = 0; vld[i] = 0; wr[i] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      unl[i] = 0; lk[i] = 0; vld[i] = 0; wr[i] = 0; addr[i] = 0; wd[i] = 0;
    end
    @(negedge clk);
    armed = 1;
    rst = 1'b0;
    check("reset locked", lkd[0], 1);
    check("reset rsp_valid", rv[0], 0);
    check("reset rsp_err", rer[0], 0);
    check("reset rsp_rdata", rd[0], 8'h00);
    check("reset clearing", clr[0], 0);
    check("reset req_ready", rdy[0], 1);

    // u0: read while locked
    drive(0, 0, 0, 1, 0, 3, 0);
    check("locked read valid", rv[0], 1);
    check("locked read err", rer[0], 1);
    check("locked read data", rd[0], 8'h00);
    check("locked read still locked", lkd[0], 1);

    // u0: unlock, write then read back-to-back
    drive(0, 1, 0, 0, 0, 0, 0);
    check("unlock opens", lkd[0], 0);
    drive(0, 0, 0, 1, 1, 5, 8'hA5);
    check("write rsp valid", rv[0], 1);
    check("write rsp err", rer[0], 0);
    drive(0, 0, 0, 1, 0, 5, 0);
    check("read-after-write data", rd[0], 8'hA5);
    check("read-after-write err", rer[0], 0);

    // u0: write into the protected region
    drive(0, 0, 0, 1, 1, 13, 8'h11);
    check("ro write err", rer[0], 1);
    check("ro write data", rd[0], 8'h00);
    drive(0, 0, 0, 1, 0, 13, 0);
    check("ro read err", rer[0], 0);

    // u0: an accept in the expiry cycle keeps the block open
    drive(0, 1, 0, 0, 0, 0, 0);
    idle(7);
    drive(0, 0, 0, 1, 0, 5, 0);
    check("accept cancels timeout", lkd[0], 0);
    check("accept cancels timeout data", rd[0], 8'hA5);
    idle(7);
    check("open after 7 idle", lkd[0], 0);
    idle(1);
    check("relock after 8 idle", lkd[0], 1);
    drive(0, 0, 0, 1, 0, 5, 0);
    check("read after timeout err", rer[0], 1);

    // u0: lock_req beats unlock_pulse
    drive(0, 1, 1, 0, 0, 0, 0);
    check("lock priority", lkd[0], 1);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    check("lock_req relocks", lkd[0], 1);

    // u1: scrub once so that every word is known
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    check("u1 scrub starts", clr[1], 1);
    idle(10);
    check("u1 scrub done", clr[1], 0);
    check("u1 locked after scrub", lkd[1], 1);
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 1, 8, 8'h11);
    check("u1 ro write err", rer[1], 1);
    drive(1, 0, 0, 1, 0, 8, 0);
    check("u1 ro read prior", rd[1], 8'h00);
    check("u1 ro read err", rer[1], 0);
    drive(1, 0, 0, 1, 0, 12, 0);
    check("u1 range read err", rer[1], 1);
    check("u1 range read data", rd[1], 8'h00);
    drive(1, 0, 0, 1, 1, 7, 8'h77);
    check("u1 write last rw", rer[1], 0);
    drive(1, 0, 0, 1, 0, 7, 0);
    check("u1 read last rw", rd[1], 8'h77);
    drive(1, 0, 0, 1, 0, 9, 0);
    check("u1 read last word", rd[1], 8'h00);
    check("u1 read last word err", rer[1], 0);
    idle(20);
    check("u1 no timeout", lkd[1], 0);

    // u2: scrub sweep; requests stall for exactly DEPTH cycles
    drive(2, 1, 0, 0, 0, 0, 0);
    drive(2, 0, 0, 1, 1, 0, 8'h3C);
    drive(2, 0, 0, 1, 1, 15, 8'h3C);
    drive(2, 0, 0, 1, 0, 15, 0);
    check("u2 read 15 before scrub", rd[2], 8'h3C);
    drive(2, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("u2 clearing c%0d", k), clr[2], 1);
      check($sformatf("u2 ready c%0d", k), rdy[2], 0);
      drive(2, 0, 0, 1, 0, 0, 0);
    end
    check("u2 clearing ends", clr[2], 0);
    check("u2 locked after scrub", lkd[2], 1);
    check("u2 stalled req no rsp", rv[2], 0);
    drive(2, 1, 0, 0, 0, 0, 0);
    drive(2, 0, 0, 1, 0, 0, 0);
    check("u2 scrubbed @0", rd[2], 8'h00);
    drive(2, 0, 0, 1, 0, 15, 0);
    check("u2 scrubbed @15", rd[2], 8'h00);

    // u2: reset in mid-sweep leaves the scrub partial; u0 response dropped
    drive(2, 0, 0, 1, 1, 15, 8'h3C);
    drive(2, 0, 1, 0, 0, 0, 0);
    idle(3);
    rst = 1'b1;
    vld[0] = 1;
    addr[0] = 4'd3;
    @(negedge clk);
    rst = 1'b0;
    vld[0] = 0;
    check("u2 reset ends scrub", clr[2], 0);
    check("u2 reset locked", lkd[2], 1);
    check("u2 reset ready", rdy[2], 1);
    check("u0 rsp dropped by reset", rv[0], 0);
    drive(2, 1, 0, 0, 0, 0, 0);
    drive(2, 0, 0, 1, 0, 15, 0);
    check("u2 partial scrub keeps @15", rd[2], 8'h3C);

    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
